// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: parametrised 3-stage approximate unsigned multiplier.
// Upper multiplier bits x[W-1:L] multiply exactly. The low L partial-product
// rows are OR-merged in pairs and truncated below column weight TRUNC.
// Each transaction can request an exact product instead.
// Optional error statistics: define APPROX_MULT_ERR_STAT_EN.
module approx_mult_pipe #(
  parameter int W     = 8,
  parameter int L     = 4,
  parameter int TRUNC = 6,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   z,
  output logic             z_exact
`ifdef APPROX_MULT_ERR_STAT_EN
  ,
  input  logic             err_clr,
  output logic [ACC_W-1:0] err_sum,
  output logic [ACC_W-1:0] op_cnt
`endif
);

  localparam int PW  = 2 * W;
  localparam int NPV = (W + 1) / 2;
  // Columns below TRUNC are dropped from every merged pair.
  localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << TRUNC;

  logic          adv;

  logic          s1Valid_q;
  logic [W-1:0]  s1X_q;
  logic [W-1:0]  s1Y_q;
  logic          s1Exact_q;

  logic          s2Valid_q;
  logic [PW-1:0] s2Hi_q;
  logic [PW-1:0] s2Low_q;
  logic          s2Exact_q;

  logic          s3Valid_q;
  logic [PW-1:0] s3Z_q;
  logic          s3Exact_q;

  logic [PW-1:0] row_d;
  logic [PW-1:0] hi_d;
  logic [PW-1:0] exLow_d;
  logic [PW-1:0] apxLow_d;
  logic [PW-1:0] pv_d [NPV];

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv      = out_ready | ~s3Valid_q;
  assign in_ready = adv;

  // Partial-product rows from the S1 operands: exact high part, exact low part,
  // and the OR-merged, truncated approximation of the low part.
  always_comb begin
    row_d    = '0;
    hi_d     = '0;
    exLow_d  = '0;
    apxLow_d = '0;
    for (int k = 0; k < NPV; k++) pv_d[k] = '0;
    for (int i = 0; i < W; i++) begin
      row_d = s1X_q[i] ? (PW'(s1Y_q) << i) : '0;
      if (i < L) begin
        exLow_d     = exLow_d + row_d;
        pv_d[i / 2] = pv_d[i / 2] | row_d;
      end else begin
        hi_d = hi_d + row_d;
      end
    end
    for (int k = 0; k < NPV; k++) begin
      apxLow_d = apxLow_d + (pv_d[k] & KEEP_MASK);
    end
  end

  // Three pipeline stages that shift together on adv and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1X_q     <= '0;
      s1Y_q     <= '0;
      s1Exact_q <= 1'b0;
      s2Valid_q <= 1'b0;
      s2Hi_q    <= '0;
      s2Low_q   <= '0;
      s2Exact_q <= 1'b0;
      s3Valid_q <= 1'b0;
      s3Z_q     <= '0;
      s3Exact_q <= 1'b0;
    end else if (adv) begin
      s1Valid_q <= in_valid;
      s1X_q     <= x;
      s1Y_q     <= y;
      s1Exact_q <= exact;
      s2Valid_q <= s1Valid_q;
      s2Hi_q    <= hi_d;
      s2Low_q   <= s1Exact_q ? exLow_d : apxLow_d;
      s2Exact_q <= s1Exact_q;
      s3Valid_q <= s2Valid_q;
      s3Z_q     <= s2Hi_q + s2Low_q;
      s3Exact_q <= s2Exact_q;
    end
  end

  assign out_valid = s3Valid_q;
  assign z         = s3Z_q;
  assign z_exact   = s3Exact_q;

`ifdef APPROX_MULT_ERR_STAT_EN
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  logic [PW-1:0]    s2Err_q;
  logic [PW-1:0]    s3Err_q;
  logic [ACC_W-1:0] errSum_q;
  logic [ACC_W-1:0] opCnt_q;
  logic [SW-1:0]    errSumExt_d;
  logic [ACC_W-1:0] errSum_d;
  logic [ACC_W-1:0] opCnt_d;

  // Error carried alongside the data; the approximation never exceeds the exact low part.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Err_q <= '0;
      s3Err_q <= '0;
    end else if (adv) begin
      s2Err_q <= exLow_d - apxLow_d;
      s3Err_q <= s2Err_q;
    end
  end

  // Saturating next values for the accumulated error and operation count.
  always_comb begin
    errSumExt_d = SW'(errSum_q) + SW'(s3Err_q);
    errSum_d    = (errSumExt_d > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : errSumExt_d[ACC_W-1:0];
    opCnt_d     = (opCnt_q == {ACC_W{1'b1}}) ? opCnt_q : opCnt_q + ACC_W'(1);
  end

  // Statistics update on each approximate result leaving the block; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errSum_q <= '0;
      opCnt_q  <= '0;
    end else if (err_clr) begin
      errSum_q <= '0;
      opCnt_q  <= '0;
    end else if (s3Valid_q && out_ready && !s3Exact_q) begin
      errSum_q <= errSum_d;
      opCnt_q  <= opCnt_d;
    end
  end

  assign err_sum = errSum_q;
  assign op_cnt  = opCnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: a default instance plus two small
// parameter sets (W=6 L=3 TRUNC=4, and W=6 L=0) driven by the same handshake.
module tb_approx_mult_pipe;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       ex;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b1;
  logic [7:0]  xIn = '0;
  logic [7:0]  yIn = '0;
  logic        exactIn = 1'b0;

  logic        inReady, outValid, zExact;
  logic [15:0] z;
  logic        inReadyB, outValidB, zExactB;
  logic [11:0] zB;
  logic        inReadyC, outValidC, zExactC;
  logic [11:0] zC;

`ifdef APPROX_MULT_ERR_STAT_EN
  logic        errClr = 1'b0;
  logic [31:0] errSum, opCnt, errSumB, opCntB, errSumC, opCntC;
  longint unsigned errModel = 0;
  longint unsigned cntModel = 0;
`endif

  int errCount = 0;
  int checkCount = 0;
  txn_t expQ[$];
  bit holdValid = 0;
  logic [15:0] holdZ;
  logic holdEx;

  always #5 clk = ~clk;

  approx_mult_pipe #(.W(8), .L(4), .TRUNC(6), .ACC_W(32)) dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .x(xIn), .y(yIn), .exact(exactIn), .out_valid(outValid),
    .out_ready(outReady), .z(z), .z_exact(zExact)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .err_clr(errClr), .err_sum(errSum), .op_cnt(opCnt)
`endif
  );

  approx_mult_pipe #(.W(6), .L(3), .TRUNC(4), .ACC_W(32)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReadyB),
    .x(xIn[5:0]), .y(yIn[5:0]), .exact(exactIn), .out_valid(outValidB),
    .out_ready(outReady), .z(zB), .z_exact(zExactB)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .err_clr(errClr), .err_sum(errSumB), .op_cnt(opCntB)
`endif
  );

  approx_mult_pipe #(.W(6), .L(0), .TRUNC(4), .ACC_W(32)) dutC (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReadyC),
    .x(xIn[5:0]), .y(yIn[5:0]), .exact(exactIn), .out_valid(outValidC),
    .out_ready(outReady), .z(zC), .z_exact(zExactC)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .err_clr(errClr), .err_sum(errSumC), .op_cnt(opCntC)
`endif
  );

  // Approximate low part: rows below l paired with OR, low columns cleared.
  function automatic longint unsigned approxLow(int l, int tr, longint unsigned xv, longint unsigned yv);
    longint unsigned lo = 0;
    longint unsigned pv;
    for (int i = 0; i < l; i += 2) begin
      pv = 0;
      if (((xv >> i) & 1) != 0) pv = pv | (yv << i);
      if (i + 1 < l && ((xv >> (i + 1)) & 1) != 0) pv = pv | (yv << (i + 1));
      lo = lo + ((pv >> tr) << tr);
    end
    return lo;
  endfunction

  function automatic longint unsigned exactLow(int l, longint unsigned xv, longint unsigned yv);
    return (xv & ((64'd1 << l) - 1)) * yv;
  endfunction

  function automatic longint unsigned modelZ(int l, int tr, longint unsigned xv, longint unsigned yv, bit ex);
    if (ex) return xv * yv;
    return (((xv >> l) * yv) << l) + approxLow(l, tr, xv, yv);
  endfunction

  task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
    checkCount++;
    if (act != exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] xv, input logic [7:0] yv, input logic ex);
    inValid = v;
    xIn     = xv;
    yIn     = yv;
    exactIn = ex;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick8;
    int r;
    r = $urandom_range(7);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  // One transaction into an empty pipe; the result must appear in the third cycle.
  task automatic checkLatency(input logic [7:0] xv, input logic [7:0] yv, input logic ex, input logic [15:0] expZ);
    outReady = 1'b1;
    applyStimulus(1'b1, xv, yv, ex);
    tick;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("latency cycle1 out_valid", outValid, 0);
    tick;
    @(negedge clk);
    checkOutput("latency cycle2 out_valid", outValid, 0);
    tick;
    @(negedge clk);
    checkOutput("latency cycle3 out_valid", outValid, 1);
    checkOutput("latency z literal", z, expZ);
    checkOutput("latency z_exact", zExact, ex);
    tick;
  endtask

  task automatic drain;
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (expQ.size() == 0) break;
      tick;
    end
    checkOutput("drain queue empty", expQ.size(), 0);
  endtask

  // Streams n transactions; inputs are held until accepted, out_ready is random
  // except for a forced stall window.
  task automatic runStream(input int n, input int validPct, input int readyPct,
                           input int stallStart, input int stallLen, input int clrAt);
    int  sent = 0;
    int  cyc = 0;
    bit  pending = 0;
    bit  accepted;
    while (sent < n && cyc < 4000) begin
      if (cyc >= stallStart && cyc < stallStart + stallLen) outReady = 1'b0;
      else outReady = ($urandom_range(99) < readyPct);
      if (!pending && $urandom_range(99) < validPct) begin
        applyStimulus(1'b1, pick8(), pick8(), 1'($urandom_range(1)));
        pending = 1;
      end
`ifdef APPROX_MULT_ERR_STAT_EN
      errClr = (cyc == clrAt);
`endif
      @(negedge clk);
      accepted = inValid && inReady;
      tick;
      if (accepted) begin
        sent++;
        pending = 0;
        inValid = 1'b0;
      end
      cyc++;
    end
`ifdef APPROX_MULT_ERR_STAT_EN
    errClr = 1'b0;
`endif
    checkOutput("stream all sent", sent, n);
    drain;
  endtask

  // Compare process: scoreboard, handshake rule, output hold and statistics.
  always @(negedge clk) begin
    txn_t t;
    if (!rst_n) begin
      expQ.delete();
      holdValid = 0;
`ifdef APPROX_MULT_ERR_STAT_EN
      errModel = 0;
      cntModel = 0;
`endif
    end else begin
      checkOutput("in_ready rule", inReady, outReady || !outValid);
      checkOutput("in_ready rule B", inReadyB, outReady || !outValidB);
      if (holdValid) begin
        checkOutput("stall out_valid held", outValid, 1);
        checkOutput("stall z held", z, holdZ);
        checkOutput("stall z_exact held", zExact, holdEx);
      end
      holdValid = outValid && !outReady;
      holdZ     = z;
      holdEx    = zExact;
`ifdef APPROX_MULT_ERR_STAT_EN
      checkOutput("err_sum", errSum, errModel);
      checkOutput("op_cnt", opCnt, cntModel);
`endif
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected output", 1, 0);
        end else begin
          t = expQ.pop_front();
          checkOutput("z", z, modelZ(4, 6, t.x, t.y, t.ex));
          checkOutput("z_exact", zExact, t.ex);
          checkOutput("B out_valid", outValidB, 1);
          checkOutput("B z", zB, modelZ(3, 4, t.x & 8'h3F, t.y & 8'h3F, t.ex));
          checkOutput("B z_exact", zExactB, t.ex);
          checkOutput("C out_valid", outValidC, 1);
          checkOutput("C z equals x*y", zC, longint'(t.x & 8'h3F) * longint'(t.y & 8'h3F));
          checkOutput("C z_exact", zExactC, t.ex);
`ifdef APPROX_MULT_ERR_STAT_EN
          if (!t.ex) begin
            errModel = errModel + exactLow(4, t.x, t.y) - approxLow(4, 6, t.x, t.y);
            if (errModel > 64'hFFFF_FFFF) errModel = 64'hFFFF_FFFF;
            if (cntModel < 64'hFFFF_FFFF) cntModel = cntModel + 1;
          end
`endif
        end
      end
`ifdef APPROX_MULT_ERR_STAT_EN
      if (errClr) begin
        errModel = 0;
        cntModel = 0;
      end
`endif
      if (inValid && inReady) begin
        t.x  = xIn;
        t.y  = yIn;
        t.ex = exactIn;
        expQ.push_back(t);
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    errCount++;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  bbX [4];
    logic [7:0]  bbY [4];
    logic        bbE [4];
    logic [15:0] bbZ [4];
    bbX = '{8'hFF, 8'h10, 8'h10, 8'hFF};
    bbY = '{8'hFF, 8'h03, 8'h03, 8'hFF};
    bbE = '{1'b1, 1'b0, 1'b1, 1'b0};
    bbZ = '{16'd65025, 16'd48, 16'd48, 16'd63632};

    // Reset state.
    #3;
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset z", z, 0);
    checkOutput("reset z_exact", zExact, 0);
    checkOutput("reset in_ready", inReady, 1);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Exact latency and the canonical approximate product.
    checkLatency(8'hFF, 8'hFF, 1'b0, 16'hF890);
`ifdef APPROX_MULT_ERR_STAT_EN
    @(negedge clk);
    checkOutput("err_sum after 0xFF*0xFF", errSum, 1393);
    checkOutput("op_cnt after 0xFF*0xFF", opCnt, 1);
    tick;
`endif

    // Back-to-back mixed modes: one result per cycle, in order.
    for (int c = 0; c < 7; c++) begin
      if (c < 4) applyStimulus(1'b1, bbX[c], bbY[c], bbE[c]);
      else inValid = 1'b0;
      @(negedge clk);
      if (c >= 3) begin
        checkOutput("b2b out_valid", outValid, 1);
        checkOutput("b2b z literal", z, bbZ[c-3]);
        checkOutput("b2b z_exact", zExact, bbE[c-3]);
      end
      tick;
    end
    drain;

    // Six transactions with a four-cycle output stall mid-stream.
    runStream(6, 100, 100, 2, 4, -1);

    // Reset with three transactions in flight.
    outReady = 1'b1;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, pick8(), pick8(), 1'($urandom_range(1)));
      tick;
    end
    inValid  = 1'b0;
    outReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", outValid, 0);
    checkOutput("mid-reset z", z, 0);
    checkOutput("mid-reset z_exact", zExact, 0);
    tick;
    rst_n = 1'b1;
    tick;
    checkLatency(8'h10, 8'h03, 1'b0, 16'd48);
    drain;

    // Random traffic with random back-pressure and a statistics clear.
    runStream(300, 70, 70, -1, 0, 40);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
